// File: rtl/glyph_text_pkg.sv
// Shared types and default geometry for the glyph text renderer.
// The default configuration is a 32x64 glyph set of 4 glyphs with 8 string slots.
package glyph_text_pkg;

  localparam int GLYPH_WIDTH_DEF  = 32;
  localparam int GLYPH_HEIGHT_DEF = 64;
  localparam int NUM_GLYPHS_DEF   = 4;
  localparam int STR_LEN_DEF      = 8;
  localparam int X_WIDTH_DEF      = 10;
  localparam int Y_WIDTH_DEF      = 10;

  localparam int col_bits      = $clog2(GLYPH_WIDTH_DEF);
  localparam int row_bits      = $clog2(GLYPH_HEIGHT_DEF);
  localparam int code_bits     = $clog2(NUM_GLYPHS_DEF);
  localparam int slot_bits     = $clog2(STR_LEN_DEF);
  localparam int rom_addr_bits = $clog2(NUM_GLYPHS_DEF * GLYPH_HEIGHT_DEF);

  typedef logic [code_bits-1:0] glyph_code_t;
  typedef logic [slot_bits-1:0] slot_idx_t;

  // Stage-1 layout for the default geometry; the top module builds the same
  // layout from its own parameters.
  typedef struct packed {
    logic                v;
    logic                in_range;
    slot_idx_t           slot;
    logic [col_bits-1:0] col;
    logic [row_bits-1:0] row;
  } s1_t;

endpackage

// File: rtl/glyph_text_slots.sv
// String slot store: one glyph code plus an occupied flag per character slot,
// with a bulk clear, a single-slot write and a combinational read by index.
module glyph_text_slots
  import glyph_text_pkg::*;
#(
  parameter int str_len_p = STR_LEN_DEF,
  parameter int code_w_p  = code_bits,
  parameter int slot_w_p  = slot_bits
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                we_i,
  input  logic [slot_w_p-1:0] addr_i,
  input  logic [code_w_p-1:0] code_i,
  input  logic                clear_i,
  input  logic [slot_w_p-1:0] rd_slot_i,
  output logic [code_w_p-1:0] rd_code_o,
  output logic                rd_occ_o
);

  logic [code_w_p-1:0]  r_code [str_len_p];
  logic [str_len_p-1:0] r_occ;

  // NOTE: the slot array is small and must read back as empty code 0 after
  // reset, so it is a reset register file rather than an inferred RAM.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < str_len_p; i++) r_code[i] <= '0;
      r_occ <= '0;
    end else begin
      if (clear_i) r_occ <= '0;
      // A write issued with a clear wins for its own slot.
      if (we_i && (32'(addr_i) < str_len_p)) begin
        r_code[addr_i] <= code_i;
        r_occ[addr_i]  <= 1'b1;
      end
    end
  end

  assign rd_code_o = (32'(rd_slot_i) < str_len_p) ? r_code[rd_slot_i] : '0;
  assign rd_occ_o  = (32'(rd_slot_i) < str_len_p) ? r_occ[rd_slot_i]  : 1'b0;

endmodule

// File: rtl/glyph_text_renderer.sv
// Two-stage pixel query pipeline over an external combinational glyph ROM.
// Define GLYPH_TEXT_SCALE2_EN to render every glyph pixel as a 2x2 block.
module glyph_text_renderer
  import glyph_text_pkg::*;
#(
  parameter int glyph_width_p  = GLYPH_WIDTH_DEF,
  parameter int glyph_height_p = GLYPH_HEIGHT_DEF,
  parameter int num_glyphs_p   = NUM_GLYPHS_DEF,
  parameter int str_len_p      = STR_LEN_DEF,
  parameter int x_width_p      = X_WIDTH_DEF,
  parameter int y_width_p      = Y_WIDTH_DEF
) (
  input  logic                                           clk_i,
  input  logic                                           reset_i,
  input  logic                                           char_we_i,
  input  logic [$clog2(str_len_p)-1:0]                   char_addr_i,
  input  logic [$clog2(num_glyphs_p)-1:0]                char_code_i,
  input  logic                                           char_clear_i,
  input  logic                                           px_v_i,
  input  logic [x_width_p-1:0]                           px_x_i,
  input  logic [y_width_p-1:0]                           px_y_i,
  output logic                                           px_ready_o,
  output logic [$clog2(num_glyphs_p*glyph_height_p)-1:0] rom_addr_o,
  input  logic [glyph_width_p-1:0]                       rom_data_i,
  output logic                                           pix_v_o,
  output logic                                           pix_o,
  input  logic                                           pix_ready_i
);

  localparam int COL_W   = $clog2(glyph_width_p);
  localparam int ROW_W   = $clog2(glyph_height_p);
  localparam int SLOT_W  = $clog2(str_len_p);
  localparam int CODE_W  = $clog2(num_glyphs_p);
  localparam int ROM_W   = $clog2(num_glyphs_p * glyph_height_p);
  localparam int STR_PIX = str_len_p * glyph_width_p;

  typedef struct packed {
    logic              v;
    logic              in_range;
    logic [SLOT_W-1:0] slot;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
  } stage1_t;

  logic [x_width_p-1:0] w_x;
  logic [y_width_p-1:0] w_y;
  logic                 w_en;
  logic                 w_in_range;
  logic [CODE_W-1:0]    w_code;
  logic                 w_occ;
  logic                 w_ink;
  stage1_t              r_s1;
  logic                 r_pix_v;
  logic                 r_pix;

`ifdef GLYPH_TEXT_SCALE2_EN
  assign w_x = px_x_i >> 1;
  assign w_y = px_y_i >> 1;
`else
  assign w_x = px_x_i;
  assign w_y = px_y_i;
`endif

  assign w_en       = !r_pix_v || pix_ready_i;
  assign px_ready_o = w_en;
  assign w_in_range = (32'(w_x) < STR_PIX) && (32'(w_y) < glyph_height_p);

  glyph_text_slots #(
    .str_len_p (str_len_p),
    .code_w_p  (CODE_W),
    .slot_w_p  (SLOT_W)
  ) u_slots (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .we_i      (char_we_i),
    .addr_i    (char_addr_i),
    .code_i    (char_code_i),
    .clear_i   (char_clear_i),
    .rd_slot_i (r_s1.slot),
    .rd_code_o (w_code),
    .rd_occ_o  (w_occ)
  );

  // Glyph height is a power of two, so code*height+row is a plain concatenation.
  assign rom_addr_o = (r_s1.v && r_s1.in_range)
                    ? ROM_W'(w_code) * ROM_W'(glyph_height_p) + ROM_W'(r_s1.row)
                    : '0;

  // MSB is the leftmost pixel; with a power-of-two width, width-1-col == ~col.
  assign w_ink = rom_data_i[~r_s1.col];

  // NOTE: pipeline state uses non-blocking assignments so both stages sample
  // pre-edge values and advance together.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_s1    <= '0;
      r_pix_v <= 1'b0;
      r_pix   <= 1'b0;
    end else if (w_en) begin
      r_s1.v <= px_v_i;
      if (px_v_i) begin
        r_s1.in_range <= w_in_range;
        r_s1.slot     <= w_x[COL_W +: SLOT_W];
        r_s1.col      <= w_x[COL_W-1:0];
        r_s1.row      <= w_y[ROW_W-1:0];
      end
      r_pix_v <= r_s1.v;
      r_pix   <= r_s1.v && r_s1.in_range && w_occ && w_ink;
    end
  end

  assign pix_v_o = r_pix_v;
  assign pix_o   = r_pix;

endmodule

// File: tb/tb_glyph_text_renderer.sv
// Self-checking bench for glyph_text_renderer: a transaction-level model of the
// string and ROM predicts every output, with literal expectations pinning it.
module tb_glyph_text_renderer;

  localparam int GW = 32;
  localparam int GH = 64;
  localparam int NG = 4;
  localparam int SL = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       char_we;
  logic [2:0] char_addr;
  logic [1:0] char_code;
  logic       char_clear;
  logic       px_v;
  logic [9:0] px_x;
  logic [9:0] px_y;
  logic       px_ready_o;
  logic [7:0] rom_addr_o;
  logic [31:0] rom_data;
  logic       pix_v_o;
  logic       pix_o;
  logic       pix_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: string contents plus the queries waiting for lookup / output.
  int m_code [SL];
  bit m_occ  [SL];
  bit m_s1_v;
  int m_s1_x, m_s1_y;
  bit m_out_v, m_out;
  bit got [$];

  always #5 clk = ~clk;

  glyph_text_renderer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .char_we_i    (char_we),
    .char_addr_i  (char_addr),
    .char_code_i  (char_code),
    .char_clear_i (char_clear),
    .px_v_i       (px_v),
    .px_x_i       (px_x),
    .px_y_i       (px_y),
    .px_ready_o   (px_ready_o),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data),
    .pix_v_o      (pix_v_o),
    .pix_o        (pix_o),
    .pix_ready_i  (pix_ready)
  );

  function automatic logic [31:0] rom_word(input int a);
    logic [31:0] h;
    case (a)
      11:      return 32'h7FC0_03FF;
      89:      return 32'h0007_FC00;
      197:     return 32'hFFFF_FFFF;
      default: begin
        h = 32'(a) * 32'h9E37_79B1;
        return h ^ (h >> 13) ^ 32'h5A5A_0F0F;
      end
    endcase
  endfunction

  assign rom_data = rom_word(int'(rom_addr_o));

  function automatic int sc(input int v);
`ifdef GLYPH_TEXT_SCALE2_EN
    return v >> 1;
`else
    return v;
`endif
  endfunction

  function automatic bit in_range(input int x, input int y);
    return (sc(x) < SL * GW) && (sc(y) < GH);
  endfunction

  function automatic int addr_of(input int x, input int y);
    if (!in_range(x, y)) return 0;
    return m_code[sc(x) / GW] * GH + sc(y);
  endfunction

  function automatic bit pixel_of(input int x, input int y);
    logic [31:0] w;
    if (!in_range(x, y) || !m_occ[sc(x) / GW]) return 1'b0;
    w = rom_word(addr_of(x, y));
    return w[GW - 1 - (sc(x) % GW)];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < SL; i++) begin
      m_code[i] = 0;
      m_occ[i]  = 1'b0;
    end
    m_s1_v  = 1'b0;
    m_out_v = 1'b0;
    m_out   = 1'b0;
  endtask

  // One clock cycle: drive inputs, check the pre-edge outputs, advance the
  // model, then check the registered outputs just after the edge.
  task automatic step(input bit v, input int x, input int y, input bit rdy,
                      input bit we = 1'b0, input int addr = 0, input int code = 0,
                      input bit clr = 1'b0);
    bit en;
    @(negedge clk);
    px_v       = v;
    px_x       = x[9:0];
    px_y       = y[9:0];
    pix_ready  = rdy;
    char_we    = we;
    char_addr  = addr[2:0];
    char_code  = code[1:0];
    char_clear = clr;
    #1;
    en = !m_out_v || rdy;
    check("px_ready", px_ready_o, en);
    check("rom_addr", rom_addr_o, m_s1_v ? addr_of(m_s1_x, m_s1_y) : 0);
    if (pix_v_o && rdy) got.push_back(pix_o);
    if (en) begin
      m_out   = m_s1_v ? pixel_of(m_s1_x, m_s1_y) : 1'b0;
      m_out_v = m_s1_v;
      m_s1_v  = v;
      m_s1_x  = x;
      m_s1_y  = y;
    end
    if (clr) for (int i = 0; i < SL; i++) m_occ[i] = 1'b0;
    if (we && addr < SL) begin
      m_code[addr] = code;
      m_occ[addr]  = 1'b1;
    end
    @(posedge clk);
    #1;
    check("pix_v", pix_v_o, m_out_v);
    if (m_out_v) check("pix", pix_o, m_out);
  endtask

  initial begin
    reset = 1'b1; char_we = 1'b0; char_addr = '0; char_code = '0; char_clear = 1'b0;
    px_v = 1'b0; px_x = '0; px_y = '0; pix_ready = 1'b0;
    reset_model();
    #1;
    check("rst_pix_v", pix_v_o, 0);
    check("rst_pix", pix_o, 0);
    check("rst_rom_addr", rom_addr_o, 0);
    check("rst_px_ready", px_ready_o, 1);
    @(negedge clk);
    reset = 1'b0;

    // Empty string: result after two cycles, no ink.
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    check("lit_empty_v", pix_v_o, 1);
    check("lit_empty", pix_o, 0);

    // Slot 0 = code 0.
    step(0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 11, 1);
    check("lit_addr11", rom_addr_o, 11);
    step(1, 0, 11, 1);
    check("lit_ink_1_11", pix_o, 1);
    step(0, 0, 0, 1);
    check("lit_ink_0_11", pix_o, 0);

    // Slot 1 = code 1.
    step(0, 0, 0, 1, 1, 1, 1);
    step(1, 45, 25, 1);
    check("lit_addr89", rom_addr_o, 89);
    step(1, 54, 25, 1);
    check("lit_ink_45_25", pix_o, 1);
    step(0, 0, 0, 1);
    check("lit_ink_54_25", pix_o, 0);
    step(0, 0, 0, 1);

    // Back-to-back with a three-cycle downstream stall.
    got.delete();
    step(1, 1, 11, 1);
    step(1, 0, 11, 1);
    repeat (3) begin
      step(1, 1, 11, 0);
      check("lit_stall_ready", px_ready_o, 0);
    end
    step(1, 1, 11, 1);
    repeat (3) step(0, 0, 0, 1);
    check("lit_order_n", got.size(), 3);
    check("lit_order", {got[0], got[1], got[2]}, 3'b101);

    // Out-of-range coordinates.
    step(1, 256, 11, 1);
    step(1, 1, 64, 1);
    check("lit_x256", pix_o, 0);
    step(0, 0, 0, 1);
    check("lit_y64", pix_o, 0);

    // Write during the lookup cycle is seen only by the next query.
    step(0, 0, 0, 1, 0, 0, 0, 1);
    step(1, 1, 11, 1);
    step(0, 0, 0, 1, 1, 0, 0);
    check("lit_old_slot", pix_o, 0);
    step(1, 1, 11, 1);
    step(0, 0, 0, 1);
    check("lit_new_slot", pix_o, 1);

    // Clear and write in the same cycle: only slot 2 remains occupied.
    step(0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 1, 1, 2, 3, 1);
    step(1, 1, 11, 1);
    step(1, 45, 25, 1);
    check("lit_clr_slot0", pix_o, 0);
    step(1, 70, 5, 1);
    check("lit_clr_slot1", pix_o, 0);
    step(0, 0, 0, 1);
    check("lit_clr_slot2", pix_o, 1);

    // Reset while the output is stalled.
    step(1, 1, 11, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("lit_stalled_v", pix_v_o, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_pix_v", pix_v_o, 0);
    check("midrst_pix", pix_o, 0);
    check("midrst_rom_addr", rom_addr_o, 0);
    reset_model();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_px_ready", px_ready_o, 1);

    // Randomized traffic against the model.
    repeat (400) begin
      step($urandom_range(0, 1), $urandom_range(0, 300), $urandom_range(0, 70),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
           $urandom_range(0, 7), $urandom_range(0, 3), ($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/glyph_text_renderer.md
Name: glyph_text_renderer

Overview:
Parametrised pixel renderer for on-screen text such as the "NEXT" and score labels.
- Holds a string of glyph codes in internal slot registers.
- Accepts pixel (x,y) queries through a valid/ready pipeline and looks up the glyph row in an external glyph ROM.
- Returns one pixel bit per query, so one block serves any glyph set and string length.
- Sits between the VGA scan/compositor logic and the existing combinational glyph ROMs.

Parameters:
glyph_width_p, 32, pixels per glyph row = ROM word width; power of two
glyph_height_p, 64, rows per glyph; power of two
num_glyphs_p, 4, glyphs in the attached ROM
str_len_p, 8, character slots in the string
x_width_p, 10, width of x query coordinate
y_width_p, 10, width of y query coordinate

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
char_we_i  in  1  write one string slot
char_addr_i  in  $clog2(str_len_p)  slot index
char_code_i  in  $clog2(num_glyphs_p)  glyph code to store; writing marks slot occupied
char_clear_i  in  1  mark all slots empty
px_v_i  in  1  query valid
px_x_i  in  x_width_p  pixel x relative to string origin
px_y_i  in  y_width_p  pixel y relative to string origin
px_ready_o  out  1  query accepted when px_v_i & px_ready_o
rom_addr_o  out  $clog2(num_glyphs_p*glyph_height_p)  glyph ROM row address (ROM is combinational)
rom_data_i  in  glyph_width_p  glyph ROM row data
pix_v_o  out  1  result valid
pix_o  out  1  pixel value; 1 = glyph ink
pix_ready_i  in  1  downstream accepts result

Behaviour:
- Reset (async, reset_i=1): all slots empty, codes 0, stage valids 0; pix_v_o=0, pix_o=0, rom_addr_o=0.
- Pipeline advance enable: en = !pix_v_o | pix_ready_i.
  - px_ready_o = en; combinational from pix_ready_i.
  - All stages hold when en=0; no query is dropped or duplicated.
- Stage 1 (capture on accept):
  - slot = x / glyph_width_p; col = x % glyph_width_p; row = y.
  - in_range = (x < str_len_p*glyph_width_p) & (y < glyph_height_p).
  - On en with no accept, s1 valid clears.
- ROM address: rom_addr_o = code[slot]*glyph_height_p + row, driven from stage-1 registers and the slot array. When s1 is invalid or out of range, rom_addr_o = 0.
- Stage 2 (on en):
  - pix_o = in_range & occupied[slot] & rom_data_i[glyph_width_p-1-col]. MSB is the leftmost pixel.
  - pix_v_o = s1 valid.
- Latency: exactly 2 cycles from accept to pix_v_o when unstalled; throughput 1 query/cycle.
- Slot occupancy and writes:
  - Slot lookup uses register contents before the clock edge. A char write in the same cycle as the lookup of that slot is not visible to that query; it is visible to the next.
  - char_clear_i and char_we_i in the same cycle: clear applies to all slots, then the write sets its slot occupied.
  - Writes are accepted regardless of pipeline stall.
  - char_addr_i >= str_len_p is ignored.
- Coordinate range: x at or beyond the string end, or y >= glyph_height_p, returns 0; no wrap-around.
- Reset mid-operation drops in-flight queries; pix_v_o falls immediately.

Optional Feature:
GLYPH_TEXT_SCALE2_EN.
- Defined: x and y are right-shifted by 1 before decode, giving 2x2 pixel replication. The range check uses the shifted values.
- Undefined: 1:1 mapping.
- Latency and handshake are identical in both builds.

Decomposition:
- Package glyph_text_pkg:
  - glyph_code_t, slot_idx_t typedefs.
  - Derived constants: col_bits = $clog2(glyph_width_p), row_bits, rom_addr_bits.
  - The s1 stage struct {v, in_range, slot, col, row}.
- Sub-module glyph_text_slots: slot register array with code and occupied bits, write/clear port, and combinational read by slot index.
- The pipeline stays in the top module.

Test Plan:
- Reset, then query x=0, y=0 -> pix_v_o after 2 cycles, pix_o=0 (all slots empty).
- With the "NEXT" ROM attached:
  - Write slot0=code0; query (1,11) -> pix_o=1 (word 0x7FC003FF, bit 30). Query (0,11) -> pix_o=0.
  - Write slot1=code1; query (45,25) -> rom_addr_o=89, pix_o=1. Query (54,25) -> pix_o=0.
- Back-to-back queries (1,11), (0,11), (1,11) with pix_ready_i held low 3 cycles mid-stream -> px_ready_o=0 while stalled; outputs 1,0,1 in order with no loss.
- Query (256,11) or (1,64) with str_len_p=8 -> pix_o=0; write slot0 and query it in the same cycle -> old value returned, next query sees the new value.
- char_clear_i with char_we_i(slot2=code3) in the same cycle -> only slot2 occupied. Assert reset_i during a stalled output -> pix_v_o=0 immediately and px_ready_o=1 after release.
